tetris_cmd_scheduler: RTL

Sequences every state-changing request to the game control logic: gravity drops, rotate, move left/right and hold swap. It owns the gravity timer, which speeds up with the level. It queues one pending request per source and arbitrates among them. Requests are handed to the control module one at a time over a valid/ready handshake. It sits between the four key debouncers and the control module, in the 25 MHz pixel clock domain.

---
 rtl/tetris_cmd_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tetris_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tetris_cmd_scheduler
// Description : Gravity timer plus one-deep request queue per source. Drop
//               requests have absolute priority; rotate/left/right/hold are
//               served round-robin. One command at a time is offered to the
//               game control logic over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_cmd_scheduler #(
    parameter int unsigned DROP_BASE = 25000000,
    parameter int unsigned DROP_STEP = 2000000,
    parameter int unsigned DROP_MIN  = 2500000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic [3:0] level,
    input  logic       move_right,
    input  logic       move_left,
    input  logic       rotate_r,
    input  logic       change,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       overrun
);

    // Interval arithmetic is done 4 bits wider than the counter so the
    // level product never wraps before the clamp comparison.
    localparam int unsigned          c_wide_w    = CNT_W + 4;
    localparam logic [c_wide_w-1:0]  c_base      = c_wide_w'(DROP_BASE);
    localparam logic [c_wide_w-1:0]  c_step      = c_wide_w'(DROP_STEP);
    localparam logic [c_wide_w-1:0]  c_min       = c_wide_w'(DROP_MIN);
    localparam logic [c_wide_w-1:0]  c_slack     = c_wide_w'(DROP_BASE - DROP_MIN);
    localparam logic [2:0]           c_code_none = 3'd0;
    localparam logic [2:0]           c_code_drop = 3'd1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Pending vector layout: [0] drop, [1] rotate, [2] left, [3] right, [4] hold
    logic [4:0]          r_pend;
    logic [4:0]          w_req;
    logic [4:0]          w_clr;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_wide_w-1:0] w_prod;
    logic [c_wide_w-1:0] w_interval;
    logic [c_wide_w-1:0] w_cnt_wide;
    logic                w_tick;
    logic                r_overrun;
    logic                w_overrun_nxt;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_code;
    logic [2:0]          w_code_nxt;
    logic [1:0]          r_rr;
    logic [1:0]          w_rr_nxt;
    logic [1:0]          w_idx;
    logic [1:0]          w_win;
    logic                w_win_vld;

    // Gravity interval from the current level, clamped at the floor
    always_comb begin
        w_prod     = c_wide_w'(level) * c_step;
        w_interval = (w_prod > c_slack) ? c_min : (c_base - w_prod);
    end

    assign w_cnt_wide = c_wide_w'(r_cnt);
    // ">=" rather than "==" so a shortened interval fires on the next edge
    assign w_tick     = run_en & (w_cnt_wide >= (w_interval - c_wide_w'(1)));
    assign w_req      = {change, move_right, move_left, rotate_r, w_tick};

    // Gravity counter: free-runs while in game, reloads on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Round-robin search over the four key sources starting at r_rr;
    // iterating downwards lets the closest pending source win.
    always_comb begin
        w_win     = r_rr;
        w_win_vld = 1'b0;
        w_idx     = r_rr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr + 2'(k);
            if (r_pend[3'(w_idx) + 3'd1]) begin
                w_win     = w_idx;
                w_win_vld = 1'b1;
            end
        end
    end

    // Next-state, command latch, grant-clear and pointer update
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_rr_nxt    = r_rr;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend[0]) begin
                    w_code_nxt  = c_code_drop;
                    w_clr[0]    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (w_win_vld) begin
                    w_code_nxt                 = 3'(w_win) + 3'd2;
                    w_clr[3'(w_win) + 3'd1]    = 1'b1;
                    w_rr_nxt                   = w_win + 2'd1;
                    w_state_nxt                = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = c_code_none;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = c_code_none;
            end
        endcase
        // Leaving the game abandons any offered command; rr survives
        if (!run_en) begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = c_code_none;
            w_rr_nxt    = r_rr;
            w_clr       = '0;
        end
    end

    // FSM state, latched command and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= c_code_none;
            r_rr    <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // A new request wins over a same-cycle grant clear, so only a hit on a
    // bit that stays pending counts as an overrun.
    assign w_overrun_nxt = run_en & (|(w_req & r_pend & ~w_clr));

    // Pending bits and the registered overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_overrun <= 1'b0;
        end else if (!run_en) begin
            r_pend    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pend    <= w_req | (r_pend & ~w_clr);
            r_overrun <= w_overrun_nxt;
        end
    end

    assign cmd_valid = (r_state == ST_ISSUE);
    assign cmd_code  = r_code;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
